// File: rtl/hc595_driver.sv
// rtl/hc595_driver.sv - serialises {seg, sel} into two cascaded 74HC595s with continuous frame refresh
module hc595_driver #(
    parameter int DIV_HALF   = 2,
    parameter int FRAME_BITS = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] sel,
    input  logic [7:0] seg,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_LATCH} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV_HALF - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    state_t      r_state, w_state;
    logic [15:0] r_shreg, w_shreg;
    logic [3:0]  r_bit_cnt, w_bit_cnt;
    logic [7:0]  r_div_cnt, w_div_cnt;
    logic        r_ds, w_ds;
    logic        r_shcp, w_shcp;
    logic        r_stcp, w_stcp;
    logic        r_oe;
    logic        r_busy;
    logic        w_div_end;
    logic        w_frame_done;

    assign w_div_end = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_state      = r_state;
        w_shreg      = r_shreg;
        w_bit_cnt    = r_bit_cnt;
        w_div_cnt    = r_div_cnt;
        w_ds         = r_ds;
        w_shcp       = r_shcp;
        w_stcp       = r_stcp;
        w_frame_done = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_shreg   = {seg, sel};
                w_ds      = seg[7];
                w_bit_cnt = 4'd0;
                w_div_cnt = 8'd0;
                w_shcp    = 1'b0;
                w_stcp    = 1'b0;
                w_state   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_div_end) begin
                    w_div_cnt = 8'd0;
                    if (!r_shcp) begin
                        w_shcp = 1'b1;
                    end else begin
                        // End of the high phase: advance data on the falling shcp edge
                        w_shcp    = 1'b0;
                        w_shreg   = {r_shreg[14:0], 1'b0};
                        w_bit_cnt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state = ST_LATCH;
                            w_stcp  = 1'b1;
                        end else begin
                            w_ds = r_shreg[14];
                        end
                    end
                end else begin
                    w_div_cnt = r_div_cnt + 8'd1;
                end
            end
            ST_LATCH: begin
                w_frame_done = w_div_end;
                if (w_div_end) begin
                    w_stcp    = 1'b0;
                    w_div_cnt = 8'd0;
                    w_state   = ST_LOAD;
                end else begin
                    w_div_cnt = r_div_cnt + 8'd1;
                end
            end
            default: w_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state   <= ST_LOAD;
            r_shreg   <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_div_cnt <= 8'd0;
            r_ds      <= 1'b0;
            r_shcp    <= 1'b0;
            r_stcp    <= 1'b0;
            r_oe      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_shreg   <= w_shreg;
            r_bit_cnt <= w_bit_cnt;
            r_div_cnt <= w_div_cnt;
            r_ds      <= w_ds;
            r_shcp    <= w_shcp;
            r_stcp    <= w_stcp;
            r_busy    <= 1'b1;
            // Display stays blanked until the first complete frame has been latched
            if (w_frame_done) begin
                r_oe <= 1'b0;
            end
        end
    end

    assign ds         = r_ds;
    assign shcp       = r_shcp;
    assign stcp       = r_stcp;
    assign oe         = r_oe;
    assign busy       = r_busy;
    assign frame_done = w_frame_done;

endmodule

// File: tb/tb_hc595_driver.sv
// tb/tb_hc595_driver.sv - self-checking bench for hc595_driver with a model 595 chain
module tb_hc595_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    logic       rst2, ds2, shcp2, stcp2, oe2, busy2, fd2;
    logic [7:0] sel2, seg2;
    logic       rst1, ds1, shcp1, stcp1, oe1, busy1, fd1;
    logic [7:0] sel1, seg1;

    hc595_driver #(.DIV_HALF(2), .FRAME_BITS(16)) u_dut2 (
        .clk(clk), .rstn(rst2), .sel(sel2), .seg(seg2),
        .ds(ds2), .shcp(shcp2), .stcp(stcp2), .oe(oe2), .busy(busy2), .frame_done(fd2)
    );

    hc595_driver #(.DIV_HALF(1), .FRAME_BITS(16)) u_dut1 (
        .clk(clk), .rstn(rst1), .sel(sel1), .seg(seg1),
        .ds(ds1), .shcp(shcp1), .stcp(stcp1), .oe(oe1), .busy(busy1), .frame_done(fd1)
    );

    logic [15:0] exp_q2[$];
    logic [15:0] exp_q1[$];

    // Model of the two cascaded 595s, sampled away from the active edge
    logic [15:0] sr2 = 16'd0, q2 = 16'd0, sr1 = 16'd0, q1 = 16'd0;
    logic        p_shcp2 = 1'b0, p_stcp2 = 1'b0, p_shcp1 = 1'b0, p_stcp1 = 1'b0;
    int          rise2 = 0, latch_cnt2 = 0, latch_cnt1 = 0;
    logic        bits2[$];

    always @(negedge clk) begin
        if (shcp2 === 1'b1 && p_shcp2 === 1'b0) begin
            sr2 <= {sr2[14:0], ds2};
            bits2.push_back(ds2);
            rise2 <= rise2 + 1;
        end
        if (stcp2 === 1'b1 && p_stcp2 === 1'b0) begin
            q2 <= sr2;
            latch_cnt2 <= latch_cnt2 + 1;
        end
        if (shcp1 === 1'b1 && p_shcp1 === 1'b0) sr1 <= {sr1[14:0], ds1};
        if (stcp1 === 1'b1 && p_stcp1 === 1'b0) begin
            q1 <= sr1;
            latch_cnt1 <= latch_cnt1 + 1;
        end
        p_shcp2 <= shcp2;
        p_stcp2 <= stcp2;
        p_shcp1 <= shcp1;
        p_stcp1 <= stcp1;
    end

    always @(negedge clk) begin
        n_vec++;
        if ((shcp2 === 1'b1 && stcp2 === 1'b1) || (shcp1 === 1'b1 && stcp1 === 1'b1)) begin
            n_fail++;
            $display("FAIL shcp_stcp_overlap t=%0t dut2=%b%b dut1=%b%b required no overlap",
                     $time, shcp2, stcp2, shcp1, stcp1);
        end
    end

    int t0;

    task automatic wait_fd(input bit use1, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(use1 ? fd1 : fd2) && n < budget);
        if ((use1 ? fd1 : fd2) !== 1'b1) begin
            n_vec++;
            n_fail++;
            $display("FAIL frame_done_timeout dut%0d waited=%0d required frame_done", use1 ? 1 : 2, n);
        end
    endtask

    task automatic test_reset();
        int n;
        rst2 = 1'b1; rst1 = 1'b1;
        seg2 = 8'hC0; sel2 = 8'hFE;
        seg1 = 8'hA5; sel1 = 8'h3C;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ds2, shcp2, stcp2, oe2, busy2, fd2} !== 6'b000100) begin
            n_fail++;
            $display("FAIL reset_outputs_dut2 got=%b required=000100", {ds2, shcp2, stcp2, oe2, busy2, fd2});
        end
        n_vec++;
        if ({ds1, shcp1, stcp1, oe1, busy1, fd1} !== 6'b000100) begin
            n_fail++;
            $display("FAIL reset_outputs_dut1 got=%b required=000100", {ds1, shcp1, stcp1, oe1, busy1, fd1});
        end
        rst2 = 1'b0;
        t0 = cyc;
        exp_q2.push_back({8'hC0, 8'hFE});
        bits2.delete();
        rise2 = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (shcp2 !== 1'b1 && n < 20);
        n_vec++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL first_shcp_rise got=%0d cycles required=3", n);
        end
        n_vec++;
        if (busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_release got=%b required=1", busy2);
        end
    endtask

    task automatic test_single_frame();
        int   w = 0;
        int   fd_at = -1;
        logic oe_at_fd = 1'bx;
        for (int k = 0; k < 100 && fd_at < 0; k++) begin
            @(negedge clk);
            if (stcp2 === 1'b1) w++;
            if (fd2 === 1'b1) begin
                fd_at = cyc - t0;
                oe_at_fd = oe2;
            end
        end
        n_vec++;
        if (fd_at != 66) begin
            n_fail++;
            $display("FAIL frame_done_cycle got=%0d required=66", fd_at);
        end
        n_vec++;
        if (w != 2) begin
            n_fail++;
            $display("FAIL stcp_width got=%0d required=2", w);
        end
        n_vec++;
        if (oe_at_fd !== 1'b1) begin
            n_fail++;
            $display("FAIL oe_before_first_frame got=%b required=1", oe_at_fd);
        end
        #1;
        n_vec++;
        if (rise2 != 16) begin
            n_fail++;
            $display("FAIL shcp_rise_count got=%0d required=16", rise2);
        end
        n_vec++;
        if (q2 !== exp_q2[0]) begin
            n_fail++;
            $display("FAIL latched_frame1 got=%h required=%h", q2, exp_q2[0]);
        end
        void'(exp_q2.pop_front());
        @(negedge clk);
        n_vec++;
        if (oe2 !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_after_first_frame got=%b required=0", oe2);
        end
    endtask

    task automatic test_bit_order();
        logic [15:0] exp_bits;
        exp_bits = 16'hC0FE;
        n_vec++;
        if (bits2.size() < 16) begin
            n_fail++;
            $display("FAIL bit_count got=%0d required=16", bits2.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_vec++;
                if (bits2[i] !== exp_bits[15-i]) begin
                    n_fail++;
                    $display("FAIL ds_bit%0d got=%b required=%b", i, bits2[i], exp_bits[15-i]);
                end
            end
        end
    endtask

    task automatic test_coherency();
        int n;
        exp_q2.push_back({8'hC0, 8'hFE});
        repeat (18) @(negedge clk);
        sel2 = 8'hFD;
        wait_fd(1'b0, 100, n);
        #1;
        n_vec++;
        if (q2 !== exp_q2[0]) begin
            n_fail++;
            $display("FAIL coherent_frame got=%h required=%h", q2, exp_q2[0]);
        end
        void'(exp_q2.pop_front());
        exp_q2.push_back({8'hC0, 8'hFD});
        wait_fd(1'b0, 100, n);
        n_vec++;
        if (n != 67) begin
            n_fail++;
            $display("FAIL frame_period got=%0d required=67", n);
        end
        #1;
        n_vec++;
        if (q2 !== exp_q2[0]) begin
            n_fail++;
            $display("FAIL updated_frame got=%h required=%h", q2, exp_q2[0]);
        end
        void'(exp_q2.pop_front());
    endtask

    task automatic test_reset_mid();
        int          n;
        int          lc;
        logic [15:0] qsave;
        repeat (39) @(negedge clk);
        lc    = latch_cnt2;
        qsave = q2;
        rst2  = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({ds2, shcp2, stcp2, oe2, busy2, fd2} !== 6'b000100) begin
            n_fail++;
            $display("FAIL midreset_outputs got=%b required=000100", {ds2, shcp2, stcp2, oe2, busy2, fd2});
        end
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (latch_cnt2 != lc || q2 !== qsave) begin
            n_fail++;
            $display("FAIL aborted_frame_latched got=%0d/%h required=%0d/%h", latch_cnt2, q2, lc, qsave);
        end
        seg2 = 8'h92; sel2 = 8'h7F;
        rst2 = 1'b0;
        exp_q2.push_back({8'h92, 8'h7F});
        wait_fd(1'b0, 200, n);
        n_vec++;
        if (n != 66) begin
            n_fail++;
            $display("FAIL post_reset_frame_done got=%0d required=66", n);
        end
        #1;
        n_vec++;
        if (q2 !== exp_q2[0] || latch_cnt2 != lc + 1) begin
            n_fail++;
            $display("FAIL post_reset_frame got=%h/%0d required=%h/%0d", q2, latch_cnt2, exp_q2[0], lc + 1);
        end
        void'(exp_q2.pop_front());
        @(negedge clk);
        n_vec++;
        if (oe2 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_oe got=%b required=0", oe2);
        end
    endtask

    task automatic test_div1();
        int          n;
        logic [31:0] shcp_trace;
        shcp_trace = 32'd0;
        rst1 = 1'b0;
        exp_q1.push_back({8'hA5, 8'h3C});
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            shcp_trace[k] = shcp1;
        end
        n_vec++;
        if (shcp_trace !== 32'hAAAA_AAAA) begin
            n_fail++;
            $display("FAIL div1_shcp_toggle got=%h required=aaaaaaaa", shcp_trace);
        end
        @(negedge clk);
        n_vec++;
        if ({fd1, stcp1, shcp1} !== 3'b110) begin
            n_fail++;
            $display("FAIL div1_latch got=%b required=110", {fd1, stcp1, shcp1});
        end
        #1;
        n_vec++;
        if (q1 !== exp_q1[0]) begin
            n_fail++;
            $display("FAIL div1_frame1 got=%h required=%h", q1, exp_q1[0]);
        end
        void'(exp_q1.pop_front());
        seg1 = 8'h5A; sel1 = 8'hC3;
        exp_q1.push_back({8'h5A, 8'hC3});
        wait_fd(1'b1, 100, n);
        n_vec++;
        if (n != 34) begin
            n_fail++;
            $display("FAIL div1_period got=%0d required=34", n);
        end
        #1;
        n_vec++;
        if (q1 !== exp_q1[0] || oe1 !== 1'b0) begin
            n_fail++;
            $display("FAIL div1_frame2 got=%h oe=%b required=%h oe=0", q1, oe1, exp_q1[0]);
        end
        void'(exp_q1.pop_front());
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bit_order();
        test_coherency();
        test_reset_mid();
        test_div1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/hc595_driver.md
Name: hc595_driver

Overview:
- Downstream of the segment-scan stage (segshow). Takes its parallel sel[7:0] and seg[7:0] outputs.
- Serialises them as a 16-bit frame into two cascaded 74HC595 shift registers that drive the board's 8-digit display.
- Refreshes continuously: each frame samples sel/seg once, shifts them out, then pulses the storage latch. This keeps the displayed pattern glitch-free while the scanner changes digits.

Parameters:
- DIV_HALF, 2, clk cycles per half-period of shcp (shcp = clk/(2*DIV_HALF)); legal range 1..255.
- FRAME_BITS, 16, bits per frame; fixed at 16 (seg byte + sel byte).

Ports:
- clk  input  1  system clock (50 MHz).
- rstn  input  1  synchronous, active-high reset.
- sel  input  8  digit select from segshow.
- seg  input  8  segment pattern from segshow.
- ds  output  1  serial data to 595 DS pin.
- shcp  output  1  595 shift clock.
- stcp  output  1  595 storage/latch clock.
- oe  output  1  595 output enable, active low.
- busy  output  1  high while a frame is in LOAD/SHIFT/LATCH (always high after reset release).
- frame_done  output  1  single-cycle pulse on the final stcp-high cycle of each frame.

Behaviour:
- Reset (rstn=1 at a clk edge):
  - State goes to LOAD; shreg=0, bit_cnt=0, div_cnt=0.
  - Outputs: ds=0, shcp=0, stcp=0, oe=1, busy=0, frame_done=0.
  - Applies from any state. A reset mid-SHIFT or mid-LATCH aborts the frame, and no stcp pulse is produced for it.
- FSM states: LOAD -> SHIFT -> LATCH -> LOAD (free-running). No idle state. busy=1 in every state once out of reset.
- LOAD (1 cycle):
  - shreg <= {seg, sel}, sampled this cycle only.
  - bit_cnt <= 0, div_cnt <= 0; shcp=0, stcp=0.
  - Input changes after the LOAD cycle have no effect until the next LOAD.
- SHIFT (32*DIV_HALF cycles):
  - ds = shreg[15] (registered; MSB first, so bit order is seg[7]..seg[0], then sel[7]..sel[0]).
  - Each bit: shcp=0 for DIV_HALF cycles, then shcp=1 for DIV_HALF cycles.
  - On the last high-phase cycle: shreg shifts left 1 (zero fill), bit_cnt increments, and shcp returns to 0 next cycle.
  - ds therefore changes only coincident with shcp falling. Setup and hold to the shcp rising edge are both DIV_HALF clk cycles.
  - After the high phase of bit 15 (bit_cnt wraps 15->0): go to LATCH.
- LATCH (DIV_HALF cycles):
  - shcp=0, stcp=1; ds holds its last value.
  - frame_done=1 on the last LATCH cycle only. Next cycle: stcp=0, state LOAD.
- Frame period: 1 + 33*DIV_HALF clk cycles (67 at DIV_HALF=2).
- oe:
  - Stays 1 from reset until the first frame completes, so no garbage shows at power-up.
  - Goes 0 on the cycle after the first frame_done and stays 0 until the next reset.
- div_cnt width is 8 bits; it compares against DIV_HALF-1. DIV_HALF=1 must work: shcp toggles every clk, and LATCH lasts 1 cycle.
- shcp and stcp are never high in the same cycle.

Test Plan:
1. Reset behaviour: hold rstn=1 for 3 cycles -> ds=shcp=stcp=0, oe=1, busy=0, frame_done=0. Release -> first shcp rising edge occurs 1+DIV_HALF cycles after release.
2. Single frame (DIV_HALF=2): seg=8'hC0, sel=8'hFE constant -> 16 shcp rising edges, then one stcp pulse 2 cycles wide. frame_done fires at cycle 66 after LOAD, and oe falls the next cycle.
3. Bit order and data: sample ds at each shcp rising edge -> 1,1,0,0,0,0,0,0,1,1,1,1,1,1,1,0. A model 595 chain holds Q = {8'hC0, 8'hFE} after stcp.
4. Coherency: change sel from 8'hFE to 8'hFD at SHIFT bit 4 -> current frame still latches 8'hFE; next frame latches 8'hFD; frame period stays exactly 67 cycles.
5. Reset mid-operation: assert rstn during bit 9 of SHIFT -> all outputs return to reset values the next cycle, no stcp pulse for the aborted frame, and oe returns to 1. After release, a full clean frame completes.
6. DIV_HALF=1 build: shcp toggles every cycle during SHIFT, frame period is 34 cycles, and the latched data matches the input sampled at LOAD. A checker asserts shcp&stcp never both high.
